// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its consumers.
package fetch_pkg;

  localparam int XLEN = 32;

  // Canonical no-op (addi x0, x0, 0)
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  // One buffered instruction together with the address it was fetched from
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Major opcodes examined by decode
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // Force an address onto a word boundary
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bus bundle between the fetch stage, instruction memory, branch resolution
// and decode.
//
// Handshake rule for every valid/ready pair below: a transfer happens at a
// rising clock edge where both valid and ready are high. The imem response
// channel has no ready; responses arrive in request order and are always
// taken.
interface fetch_if;
  import fetch_pkg::*;

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            dec_valid;
  logic [XLEN-1:0] dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic            dec_ready;

  // View of the fetch stage itself
  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, dec_ready
  );

  // View of the surrounding memory / control / decode environment
  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, dec_ready
  );

endinterface

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched instructions. The head entry is read
// straight from registered storage; flush empties it in one cycle.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  fetch_entry_t                 push_data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output fetch_entry_t                 head_o,
  output logic [$clog2(DEPTH+1)-1:0]   occ_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign occ_o   = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Next-state pointers and occupancy; flush overrides both push and pop
  always_comb begin
    do_push  = push_i & ~flush_i;
    do_pop   = pop_i & ~empty_o & ~flush_i;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + CNT_W'(1);
    if (!do_push && do_pop) cnt_d = cnt_q - CNT_W'(1);
  end

  // Pointer/occupancy registers
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // A push into a full buffer is legal only when the head leaves in the same cycle
  always_ff @(posedge clk) begin
    if (rst_n && !flush_i && push_i && full_o) begin
      assert (pop_i) else $error("fetch_buffer: push while full without pop");
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited imem requests,
// in-order response capture and redirect/flush handling.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input logic     clk,
  input logic     rst_n,
  fetch_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             en_q;

  logic [CNT_W-1:0] occ;
  logic             buf_empty, buf_full;
  fetch_entry_t     head, push_entry;
  logic             req_fire, resp_keep, dec_fire;
  logic [XLEN-1:0]  redirect_base;
  logic [SUM_W-1:0] credit_used;

  // Credit: buffered entries plus in-flight requests may never exceed DEPTH,
  // so every response that is kept is guaranteed a buffer slot.
  assign credit_used        = SUM_W'(occ) + SUM_W'(outstanding_q);
  assign bus.imem_req_valid = en_q & ~bus.redirect_valid & (credit_used < SUM_W'(DEPTH));
  assign bus.imem_req_addr  = fetch_pc_q;

  // Decode sees the head entry; an empty buffer presents zeros
  assign bus.dec_valid = ~buf_empty;
  assign bus.dec_instr = buf_empty ? '0 : head.instr;
  assign bus.dec_pc    = buf_empty ? '0 : head.pc;

  // Handshakes and next-state of PCs and counters; redirect wins over everything
  always_comb begin
    redirect_base = align_word(bus.redirect_pc);
    req_fire      = bus.imem_req_valid & bus.imem_req_ready;
    resp_keep     = bus.imem_resp_valid & ~bus.redirect_valid & (drop_q == '0);
    dec_fire      = bus.dec_valid & bus.dec_ready & ~bus.redirect_valid;
    push_entry    = '{pc: resp_pc_q, instr: bus.imem_resp_data};

    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(bus.imem_resp_valid);

    drop_d = drop_q;
    if (bus.redirect_valid) begin
      // Everything still in flight after this edge belongs to the old path
      drop_d = outstanding_d;
    end else if (bus.imem_resp_valid && (drop_q != '0)) begin
      drop_d = drop_q - CNT_W'(1);
    end

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = redirect_base;
      resp_pc_d  = redirect_base;
    end else begin
      if (req_fire)  fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (resp_keep) resp_pc_d  = resp_pc_q + XLEN'(4);
    end
  end

  // Stage state; request issue starts one cycle after reset is released
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      en_q          <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      en_q          <= 1'b1;
    end
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (resp_keep),
    .push_data_i (push_entry),
    .pop_i       (dec_fire),
    .flush_i     (bus.redirect_valid),
    .head_o      (head),
    .occ_o       (occ),
    .empty_o     (buf_empty),
    .full_o      (buf_full)
  );

  // A kept response must find room unless decode frees the head in the same cycle
  always_ff @(posedge clk) begin
    if (rst_n && resp_keep && buf_full) begin
      assert (dec_fire) else $error("fetch_unit: imem response with full buffer");
    end
  end

endmodule
